// File: rtl/divide_restoring_pkg.sv
// Shared types for the restoring divider.
// DIVIDE_RESTORING_SIGNED_EN enables the FIXUP state in the top.
package divide_restoring_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIXUP,
    DONE
  } state_t;

  localparam logic [63:0] DBZ_QUOTIENT = '1;

endpackage

// File: rtl/divide_restoring_step.sv
// One combinational restoring-division step.
// Trial-subtracts D from {R, Q msb} and restores on borrow.
module divide_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] r,
  input  logic             q_msb,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] r_next,
  output logic             q_bit
);

  logic [WIDTH:0] trial;

  assign trial  = {r, q_msb} - {1'b0, d};
  assign q_bit  = ~trial[WIDTH];
  // R < D holds on entry, so the restored value fits in WIDTH bits
  assign r_next = q_bit ? trial[WIDTH-1:0]
                        : {r[WIDTH-2:0], q_msb};

endmodule

// File: rtl/divide_restoring.sv
// Iterative restoring divider, one quotient bit per enabled cycle.
// Define DIVIDE_RESTORING_SIGNED_EN for two's-complement operands.
module divide_restoring
  import divide_restoring_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [WIDTH-1:0] DBZ_Q    = DBZ_QUOTIENT[WIDTH-1:0];

  state_t           state, state_n;
  logic [WIDTH-1:0] r_q, q_q, d_q;
  logic [WIDTH-1:0] r_n, q_n, d_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             busy_n, done_n, dbz_n;
  logic [WIDTH-1:0] quo_n, rem_n;
  logic [WIDTH-1:0] step_r, q_shift;
  logic             step_bit;
  logic [WIDTH-1:0] dvd_mag, dsr_mag;

`ifdef DIVIDE_RESTORING_SIGNED_EN
  logic sign_q, sign_r, sign_q_n, sign_r_n;

  assign dvd_mag = dividend[WIDTH-1] ? -dividend : dividend;
  assign dsr_mag = divisor[WIDTH-1]  ? -divisor  : divisor;
`else
  assign dvd_mag = dividend;
  assign dsr_mag = divisor;
`endif

  divide_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .r      (r_q),
    .q_msb  (q_q[WIDTH-1]),
    .d      (d_q),
    .r_next (step_r),
    .q_bit  (step_bit)
  );

  assign q_shift = {q_q[WIDTH-2:0], step_bit};

  always_comb begin
    state_n = state;
    r_n     = r_q;
    q_n     = q_q;
    d_n     = d_q;
    cnt_n   = cnt;
    busy_n  = busy;
    done_n  = done;
    quo_n   = quotient;
    rem_n   = remainder;
    dbz_n   = div_by_zero;
`ifdef DIVIDE_RESTORING_SIGNED_EN
    sign_q_n = sign_q;
    sign_r_n = sign_r;
`endif
    unique case (state)
      IDLE: begin
        if (start) begin
          if (divisor == '0) begin
            state_n = DONE;
            done_n  = 1'b1;
            quo_n   = DBZ_Q;
            rem_n   = dividend;
            dbz_n   = 1'b1;
          end else begin
            state_n = RUN;
            busy_n  = 1'b1;
            r_n     = '0;
            q_n     = dvd_mag;
            d_n     = dsr_mag;
            cnt_n   = CNT_INIT;
`ifdef DIVIDE_RESTORING_SIGNED_EN
            sign_q_n = dividend[WIDTH-1] ^ divisor[WIDTH-1];
            sign_r_n = dividend[WIDTH-1];
`endif
          end
        end
      end
      RUN: begin
        r_n   = step_r;
        q_n   = q_shift;
        cnt_n = cnt - CNT_ONE;
        if (cnt == CNT_ONE) begin
`ifdef DIVIDE_RESTORING_SIGNED_EN
          state_n = FIXUP;
`else
          state_n = DONE;
          busy_n  = 1'b0;
          done_n  = 1'b1;
          quo_n   = q_shift;
          rem_n   = step_r;
          dbz_n   = 1'b0;
`endif
        end
      end
      FIXUP: begin
`ifdef DIVIDE_RESTORING_SIGNED_EN
        // (-min)/(-1) wraps back to min through the negate
        state_n = DONE;
        busy_n  = 1'b0;
        done_n  = 1'b1;
        quo_n   = sign_q ? -q_q : q_q;
        rem_n   = sign_r ? -r_q : r_q;
        dbz_n   = 1'b0;
`else
        state_n = IDLE;
`endif
      end
      DONE: begin
        state_n = IDLE;
        done_n  = 1'b0;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      r_q         <= '0;
      q_q         <= '0;
      d_q         <= '0;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (en) begin
      state       <= state_n;
      r_q         <= r_n;
      q_q         <= q_n;
      d_q         <= d_n;
      cnt         <= cnt_n;
      busy        <= busy_n;
      done        <= done_n;
      quotient    <= quo_n;
      remainder   <= rem_n;
      div_by_zero <= dbz_n;
    end
  end

`ifdef DIVIDE_RESTORING_SIGNED_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_q <= 1'b0;
      sign_r <= 1'b0;
    end else if (en) begin
      sign_q <= sign_q_n;
      sign_r <= sign_r_n;
    end
  end
`endif

endmodule

// File: tb/tb_divide_restoring.sv
// Directed and random bench for divide_restoring at WIDTH=8.
// Expected results come from a behavioural divide model via a scoreboard.
module tb_divide_restoring;

  localparam int W = 8;
`ifdef DIVIDE_RESTORING_SIGNED_EN
  localparam int LAT = W + 2;
`else
  localparam int LAT = W + 1;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    int           lat;
    int           busy_cnt;
  } exp_t;

  exp_t         sb[$];
  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] held_q = '0;

  divide_restoring #(
    .WIDTH (W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a,
                                 input logic [W-1:0] b);
    exp_t e;
    int   sa, sd;
    e.dbz      = 1'b0;
    e.lat      = LAT;
    e.busy_cnt = LAT - 1;
    sa = 0;
    sd = 1;
    if (b == '0) begin
      e.q        = '1;
      e.r        = a;
      e.dbz      = 1'b1;
      e.lat      = 1;
      e.busy_cnt = 0;
    end
`ifdef DIVIDE_RESTORING_SIGNED_EN
    else if (a == 8'h80 && b == 8'hff) begin
      e.q = 8'h80;
      e.r = '0;
    end else begin
      sa  = int'($signed(a));
      sd  = int'($signed(b));
      e.q = W'(sa / sd);
      e.r = W'(sa % sd);
    end
`else
    else begin
      e.q = a / b;
      e.r = a % b;
    end
`endif
    return e;
  endfunction

  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b,
                         input int stall_at, input int abort_at,
                         input bit noise);
    exp_t e, got;
    bit   seen;
    int   busy_seen;
    @(negedge clk);
    chk("done_one_pulse", 32'(done), 32'(0));
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    en       = 1'b1;
    e = model(a, b);
    if (stall_at > 0) begin
      e.lat      += 3;
      e.busy_cnt += 3;
    end
    sb.push_back(e);
    seen      = 1'b0;
    busy_seen = 0;
    for (int k = 1; k <= 40 && !seen; k++) begin
      @(negedge clk);
      if (en && done) begin
        seen = 1'b1;
        got  = sb.pop_front();
        chk("latency", 32'(k), 32'(got.lat));
        chk("busy_cycles", 32'(busy_seen), 32'(got.busy_cnt));
        chk("busy_at_done", 32'(busy), 32'(0));
        chk("quotient", 32'(quotient), 32'(got.q));
        chk("remainder", 32'(remainder), 32'(got.r));
        chk("div_by_zero", 32'(div_by_zero), 32'(got.dbz));
        held_q = got.q;
      end else begin
        if (busy) busy_seen++;
        if (!en) begin
          chk("stall_done", 32'(done), 32'(0));
          chk("stall_busy", 32'(busy), 32'(1));
          chk("stall_q_held", 32'(quotient), 32'(held_q));
        end
      end
      start    = 1'b0;
      dividend = W'($urandom);
      divisor  = W'($urandom);
      if (noise && k == 3) start = 1'b1;
      if (stall_at > 0 && k == stall_at) en = 1'b0;
      if (stall_at > 0 && k == stall_at + 3) en = 1'b1;
      if (k == abort_at) begin
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'(0));
        chk("abort_done", 32'(done), 32'(0));
        chk("abort_q", 32'(quotient), 32'(0));
        chk("abort_r", 32'(remainder), 32'(0));
        chk("abort_dbz", 32'(div_by_zero), 32'(0));
        void'(sb.pop_front());
        held_q = '0;
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
    end
    if (!seen) begin
      checks++;
      assert (seen) else begin
        errors++;
        $error("FAIL done_timeout: observed no done expected done");
      end
      void'(sb.pop_front());
    end
  endtask

  initial begin
    rst_n = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_q", 32'(quotient), 32'(0));
    chk("rst_r", 32'(remainder), 32'(0));
    chk("rst_dbz", 32'(div_by_zero), 32'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b1;

    run_div(8'd200, 8'd7, 0, 0, 1'b0);
    run_div(8'd13, 8'd0, 0, 0, 1'b0);
    run_div(8'd5, 8'd9, 0, 0, 1'b1);
    run_div(8'd255, 8'd1, 0, 0, 1'b1);
    run_div(8'd100, 8'd10, 4, 0, 1'b0);
    run_div(8'd77, 8'd3, 0, 4, 1'b0);
    run_div(8'd9, 8'd2, 0, 0, 1'b0);
`ifdef DIVIDE_RESTORING_SIGNED_EN
    run_div(8'h9c, 8'd7, 0, 0, 1'b0);
    run_div(8'h80, 8'hff, 0, 0, 1'b0);
    run_div(8'h80, 8'h00, 0, 0, 1'b0);
`endif
    for (int i = 0; i < 16; i++) begin
      run_div(W'($urandom), W'($urandom_range(0, 40)), 0, 0, i[0]);
    end

    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("idle_no_done", 32'(done), 32'(0));
    end
    chk("scoreboard_empty", 32'(sb.size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/divide_restoring.md
Name: divide_restoring

Overview:
- Iterative restoring integer divider. It is the inverse of the accumulator: it finds how many times a divisor can be subtracted from a dividend, producing one quotient bit per cycle.
- Serves arithmetic datapaths that need averages and ratios from accumulated sums. Examples: sum/count, scale factors.
- start/done handshake with a clock enable, in the same style as the other arithmetic blocks.

Parameters:
- WIDTH, 16, bit width of dividend, divisor, quotient and remainder.
- CNT_W, $clog2(WIDTH+1), width of the internal step counter. Derived; not to be overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  clock enable. When low, all state and outputs hold.
- start  input  1  request a division. Sampled only in IDLE with en high.
- dividend  input  WIDTH  numerator, captured on an accepted start.
- divisor  input  WIDTH  denominator, captured on an accepted start.
- busy  output  1  high from the cycle after accept until done.
- done  output  1  one-cycle pulse; results are valid from this cycle on.
- quotient  output  WIDTH  result quotient, held until the next done.
- remainder  output  WIDTH  result remainder, held until the next done.
- div_by_zero  output  1  set with done when divisor==0; held until the next done.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; busy=0, done=0, quotient=0, remainder=0, div_by_zero=0; internal registers and counter cleared.
- Reset mid-operation aborts immediately. No done is produced; outputs are zeroed.
- en low: the FSM, counter and working registers freeze. A done pulse that is due is deferred. done is registered and so stretches while en is low; the bench counts done only on en-high cycles.
- IDLE, start=1 (en=1), divisor!=0:
  - capture operands: partial remainder R=0, working quotient Q=dividend, D=divisor;
  - counter=WIDTH, go to RUN, busy=1.
- IDLE, start=1 (en=1), divisor==0:
  - go directly to DONE;
  - quotient={WIDTH{1'b1}}, remainder=dividend, div_by_zero=1.
- RUN, one step per enabled cycle:
  - T = {R,Q[MSB]} - {1'b0,D}, computed at WIDTH+1 bits;
  - if T is non-negative: R=T[WIDTH-1:0] and shift 1 into Q;
  - otherwise: R={R,Q[MSB]} (restore) and shift 0 into Q;
  - decrement the counter; when the counter reaches 1, go to DONE.
- DONE: register quotient=Q and remainder=R, assert done=1 for one cycle, busy=0, return to IDLE.
- Latency: the accept edge plus WIDTH RUN cycles, then done in cycle WIDTH+1 after the accept edge (en held high). Divide-by-zero: done in cycle 1.
- start while busy or in DONE is ignored (no queueing). Back-to-back operation is allowed: start may be accepted in the IDLE cycle right after done.
- Operand inputs are don't-care except at the accept cycle.
- Invariant for non-zero divisor: dividend == quotient*divisor + remainder, with remainder < divisor (unsigned).

Optional Feature:
- Macro: DIVIDE_RESTORING_SIGNED_EN.
- Defined: operands and results are two's complement.
  - Accept captures the magnitudes and records sign_q = dividend sign XOR divisor sign, and sign_r = dividend sign.
  - An extra FIXUP state between RUN and DONE negates the quotient if sign_q is set and the remainder if sign_r is set. Latency becomes WIDTH+2.
  - Overflow case (most negative)/(-1): quotient = most negative (wraps), remainder=0, div_by_zero=0.
  - Divide by zero: quotient=-1, remainder=dividend.
- Undefined: unsigned only. No FIXUP state; latency WIDTH+1.

Decomposition:
- Package divide_restoring_pkg:
  - state enum {IDLE, RUN, FIXUP, DONE}; FIXUP is reachable only with the macro defined;
  - localparam DBZ_QUOTIENT all-ones.
- One natural sub-module, divide_step:
  - purely combinational single restoring step;
  - inputs R, Q MSB, D; outputs next R and quotient bit;
  - kept separate so it can be unit-tested exhaustively at WIDTH=4.

Test Plan (WIDTH=8, en=1 unless stated):
- 200/7 → done 9 cycles after accept; quotient=28, remainder=4, div_by_zero=0; busy high for cycles 1..8.
- 13/0 → done 1 cycle after accept; quotient=255, remainder=13, div_by_zero=1.
- 5/9 then back-to-back 255/1 (start in the IDLE cycle after the first done) → q=0,r=5; then q=255,r=0; start pulses during busy have no effect.
- 100/10 with en low for 3 cycles mid-RUN → done 12 cycles after accept; q=10, r=0; outputs frozen during the stall.
- 77/3, rst_n low in RUN cycle 4 → all outputs 0 immediately, no done; a following 9/2 gives q=4, r=1.
- With DIVIDE_RESTORING_SIGNED_EN:
  - -100/7 → q=-14, r=-2, done 10 cycles after accept;
  - -128/-1 → q=-128, r=0.
